// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default geometry and Gray/binary
// pointer conversion helpers used by both the write- and read-side controllers.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 3;
    localparam int unsigned DEPTH          = 1 << ADDR_WIDTH_DEF;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Bits at and above w must be zero in g.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
        logic [31:0] b;
        b = g;
        for (int unsigned s = 1; s < 32; s++) begin
            if (s < w) begin
                b = b ^ (g >> s);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full-flag controller of the asynchronous FIFO.
//   clk, rst_n    write clock, async active-low reset
//   winc          producer write request
//   rptr_sync     Gray read pointer, already synchronized into clk
//   wen           RAM write enable (combinational)
//   waddr         RAM write address
//   wptr          registered Gray write pointer to the read-domain sync
//   wfull         registered full flag
//   walmost_full  registered level >= AFULL_THRESH
//   wlevel        registered fill-level estimate (0..DEPTH)
//   wovf          one-cycle pulse per write rejected while full
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wgray_q,  wgray_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q,   wovf_d;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_gray;
    logic          accept;

    // Next-state: pointer advance, full compare, level estimate, overflow.
    always_comb begin
        accept    = winc & ~wfull_q & rst_n;
        wbin_d    = wbin_q + PW'(accept);
        wgray_d   = PW'(bin2gray(32'(wbin_d)));
        rbin_s    = PW'(gray2bin(32'(rptr_sync), PW));
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_gray = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};
        wfull_d   = (wgray_d == full_gray);
        wlevel_d  = wbin_d - rbin_s;
        wafull_d  = (wlevel_d >= PW'(AFULL_THRESH));
        wovf_d    = winc & wfull_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    // Held low during reset so no RAM write can occur while the pointers are cleared.
    assign wen          = accept;
    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr         = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [3:0] rptr_sync;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       wovf;

    wptr_full_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .rptr_sync    (rptr_sync),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic       wfull;
        logic       wafull;
        logic [3:0] wlevel;
        logic       wovf;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Bench-side model: counts of accepted writes and of reads the sync has delivered.
    int   m_wr;
    int   m_rd;
    logic m_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference Gray sequence for a 4-bit counter.
    function automatic logic [3:0] gray4(input int n);
        case (n % 16)
            0: return 4'h0;   1: return 4'h1;   2: return 4'h3;   3: return 4'h2;
            4: return 4'h6;   5: return 4'h7;   6: return 4'h5;   7: return 4'h4;
            8: return 4'hC;   9: return 4'hD;  10: return 4'hF;  11: return 4'hE;
           12: return 4'hA;  13: return 4'hB;  14: return 4'h9;  default: return 4'h8;
        endcase
    endfunction

    task automatic model_reset();
        m_wr   = 0;
        m_rd   = 0;
        m_full = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wen"},    32'(wen),          32'd0);
        chk({tag, "_waddr"},  32'(waddr),        32'd0);
        chk({tag, "_wptr"},   32'(wptr),         32'd0);
        chk({tag, "_wfull"},  32'(wfull),        32'd0);
        chk({tag, "_wafull"}, 32'(walmost_full), 32'd0);
        chk({tag, "_wlevel"}, 32'(wlevel),       32'd0);
        chk({tag, "_wovf"},   32'(wovf),         32'd0);
    endtask

    // One clock: drive inputs, predict, clock, compare against scoreboard.
    task automatic cycle(input logic w, input int rd);
        exp_t e;
        int   lvl;
        logic acc;
        winc      = w;
        rptr_sync = gray4(rd);
        m_rd      = rd;
        #1;
        acc = w && !m_full;
        chk("wen", 32'(wen), 32'(acc));
        if (acc) m_wr++;
        lvl      = (m_wr - m_rd) & 15;
        e.wptr   = gray4(m_wr);
        e.waddr  = 3'(m_wr % 8);
        e.wlevel = 4'(lvl);
        e.wfull  = (lvl == 8);
        e.wafull = (lvl >= 6);
        e.wovf   = w && m_full;
        m_full   = e.wfull;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("wptr",   32'(wptr),         32'(e.wptr));
            chk("waddr",  32'(waddr),        32'(e.waddr));
            chk("wfull",  32'(wfull),        32'(e.wfull));
            chk("wafull", 32'(walmost_full), 32'(e.wafull));
            chk("wlevel", 32'(wlevel),       32'(e.wlevel));
            chk("wovf",   32'(wovf),         32'(e.wovf));
        end
    endtask

    // Async reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int rd;
        rst_n     = 1'b0;
        winc      = 1'b1;
        rptr_sync = 4'b0110;
        model_reset();

        // 1. Reset with winc active and a non-zero read pointer.
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_rst");
        rst_n = 1'b1;
        m_rd  = 4;
        cycle(1'b1, 4);
        chk("first_wptr", 32'(wptr), 32'h1);

        // 2. Fill from empty.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 0);
        chk("full_wptr", 32'(wptr), 32'hC);

        // 3. Two rejected writes, then idle.
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        cycle(1'b0, 0);

        // 4. One read frees a slot, then refill.
        cycle(1'b0, 1);
        cycle(1'b1, 1);
        chk("refill_wptr", 32'(wptr), 32'hD);

        // 5. Wrap: 16 writes with the read pointer trailing by two.
        do_reset();
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        for (int i = 0; i < 14; i++) cycle(1'b1, m_wr - 1);
        chk("wrap_wptr", 32'(wptr), 32'h0);

        // 6. Simultaneous write and read at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 0);
        cycle(1'b1, 1);
        cycle(1'b1, 2);
        chk("simul_lvl", 32'(wlevel), 32'd5);

        // Random traffic; reads never overtake accepted writes.
        rd = m_rd;
        for (int i = 0; i < 60; i++) begin
            if (rd < m_wr && $urandom_range(0, 2) == 0) rd++;
            cycle(1'($urandom_range(0, 1)), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
